cla_subtractor_seq: RTL and testbench



---
 rtl/cla_subtractor_seq.sv | 121 ++++++++++++
 tb/tb_cla_subtractor_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cla_subtractor_seq.sv
// Sequential two's-complement subtractor: Diff = A - B - Borrow_In, resolved one
// carry-lookahead slice per clock with a Start/Busy/Done handshake.
module cla_subtractor_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Borrow_In,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow_Out,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned NSlices = WIDTH / SLICE;
  localparam int unsigned CntW    = (NSlices > 1) ? $clog2(NSlices) : 1;
  localparam logic [CntW-1:0] LastSlice = CntW'(NSlices - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic [WIDTH-1:0] work_q;
  logic             carry_q;

  int unsigned      base;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] snb;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic [SLICE-1:0] s;
  logic             term;
  logic [WIDTH-1:0] work_nxt;

  // Slice adder on A + ~B + ~Borrow_In; each carry is a flat sum-of-products.
  always_comb begin
    base = 32'(cnt_q) * SLICE;
    sa   = a_q[base +: SLICE];
    snb  = nb_q[base +: SLICE];
    g    = sa & snb;
    p    = sa ^ snb;
    c    = '0;
    term = 1'b0;
    c[0] = carry_q;
    for (int i = 0; i < int'(SLICE); i++) begin
      term = carry_q;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    s        = p ^ c[SLICE-1:0];
    work_nxt = work_q;
    work_nxt[base +: SLICE] = s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_q        <= '0;
      nb_q       <= '0;
      work_q     <= '0;
      carry_q    <= 1'b0;
      Diff       <= '0;
      Borrow_Out <= 1'b0;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          Done <= 1'b0;
          if (Start) begin
            a_q     <= A;
            nb_q    <= ~B;
            carry_q <= ~Borrow_In;
            cnt_q   <= '0;
            work_q  <= '0;
            Busy    <= 1'b1;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          work_q  <= work_nxt;
          carry_q <= c[SLICE];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastSlice) begin
            Diff       <= work_nxt;
            Borrow_Out <= ~c[SLICE];
            // nb_q holds ~B, so equal MSBs mean A and B differ in sign.
            Overflow   <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                          (work_nxt[WIDTH-1] != a_q[WIDTH-1]);
            Busy       <= 1'b0;
            Done       <= 1'b1;
            state_q    <= StDone;
          end
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// Directed and randomized checks of cla_subtractor_seq: handshake timing, flags,
// Start-while-busy, reset mid-operation and back-to-back throughput.
module tb_cla_subtractor_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Borrow_In = 1'b0;
  logic [15:0] Diff;
  logic        Borrow_Out;
  logic        Overflow;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] prev_diff = '0;

  cla_subtractor_seq #(.WIDTH(16), .SLICE(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Borrow_In (Borrow_In),
    .Diff      (Diff),
    .Borrow_Out(Borrow_Out),
    .Overflow  (Overflow),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated operation; operands are scrambled right after acceptance.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input logic [15:0] ed, input logic ebo,
                       input logic eov);
    A = a; B = b; Borrow_In = bin; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Borrow_In = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_nodone"}, 32'(Done), 32'd0);
      chk({tag, "_hold"}, 32'(Diff), 32'(prev_diff));
      tick();
    end
    chk({tag, "_done"}, 32'(Done), 32'd1);
    chk({tag, "_busy_lo"}, 32'(Busy), 32'd0);
    chk({tag, "_diff"}, 32'(Diff), 32'(ed));
    chk({tag, "_bo"}, 32'(Borrow_Out), 32'(ebo));
    chk({tag, "_ov"}, 32'(Overflow), 32'(eov));
    prev_diff = ed;
    tick();
    chk({tag, "_done_1cyc"}, 32'(Done), 32'd0);
  endtask

  logic [15:0] ra [0:1];
  logic [15:0] rb [0:1];
  logic        rc [0:1];
  logic [16:0] ref_full;
  logic        ref_ov;

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bo", 32'(Borrow_Out), 32'd0);
    chk("rst_ov", 32'(Overflow), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);

    do_op("basic",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    do_op("under0",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    do_op("under1",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op("ovneg",   16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    do_op("ovpos",   16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Start while busy is ignored
    A = 16'h00FF; B = 16'h000F; Borrow_In = 1'b0; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    A = 16'h1111; B = 16'h2222; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    chk("sib_done", 32'(Done), 32'd1);
    chk("sib_diff", 32'(Diff), 32'h00F0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sib_nodone", 32'(Done), 32'd0);
      chk("sib_idle", 32'(Busy), 32'd0);
    end
    chk("sib_hold", 32'(Diff), 32'h00F0);

    // Reset in the second RUN cycle
    A = 16'h0003; B = 16'h0001; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_diff", 32'(Diff), 32'd0);
    chk("rmid_bo", 32'(Borrow_Out), 32'd0);
    chk("rmid_ov", 32'(Overflow), 32'd0);
    chk("rmid_busy", 32'(Busy), 32'd0);
    chk("rmid_done", 32'(Done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rmid_nodone", 32'(Done), 32'd0);
    end
    prev_diff = 16'h0000;
    do_op("after_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0);

    // Back-to-back random sweep with Start held high: a result every 5 cycles
    ra[0] = 16'($urandom); rb[0] = 16'($urandom); rc[0] = 1'($urandom);
    A = ra[0]; B = rb[0]; Borrow_In = rc[0]; Start = 1'b1;
    tick();
    for (int n = 0; n < 10000; n++) begin
      ra[1] = 16'($urandom); rb[1] = 16'($urandom); rc[1] = 1'($urandom);
      if (n == 0) begin
        ra[1] = 16'hFFFF; rb[1] = 16'hFFFF; rc[1] = 1'b1;
      end
      A = ra[1]; B = rb[1]; Borrow_In = rc[1];
      for (int i = 0; i < 3; i++) begin
        tick();
        if (Done !== 1'b0) chk("b2b_early", 32'(Done), 32'd0);
      end
      tick();
      ref_full = {1'b0, ra[0]} - {1'b0, rb[0]} - {16'd0, rc[0]};
      ref_ov   = (ra[0][15] != rb[0][15]) && (ref_full[15] != ra[0][15]);
      chk("b2b_done", 32'(Done), 32'd1);
      chk("b2b_diff", 32'(Diff), 32'(ref_full[15:0]));
      chk("b2b_bo", 32'(Borrow_Out), 32'(ref_full[16]));
      chk("b2b_ov", 32'(Overflow), 32'(ref_ov));
      if (n_err > 20) break;
      ra[0] = ra[1]; rb[0] = rb[1]; rc[0] = rc[1];
      tick();
    end
    Start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
